// File: rtl/spi_psram_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_psram_responder_pkg: shared types and SPI command codes         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package spi_psram_responder_pkg;

  typedef enum logic [1:0] {
    SYS_RESET = 2'd0,
    SYS_RUN   = 2'd1,
    SYS_HALT  = 2'd2
  } sys_state_t;

  typedef enum logic [0:0] {
    MEM_INTERNAL = 1'b0,
    MEM_PSRAM    = 1'b1
  } mem_type_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_IGNORE  = 3'd5
  } spi_resp_state_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

endpackage
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_input_sync: 2-FF synchronizers plus registered SCLK/CS edges    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spi_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_rise,
  output logic o_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_mosi
);

  logic [1:0] r_sclk_s, r_cs_s, r_mosi_s;
  logic       r_sclk_d, r_cs_d;
  logic       r_rise, r_fall, r_cs_fall, r_cs_rise, r_mosi;

  // CS chain resets high so leaving reset never looks like a select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s  <= 2'b00;
      r_cs_s    <= 2'b11;
      r_mosi_s  <= 2'b00;
      r_sclk_d  <= 1'b0;
      r_cs_d    <= 1'b1;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_cs_fall <= 1'b0;
      r_cs_rise <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_sclk_s  <= {r_sclk_s[0], i_sclk};
      r_cs_s    <= {r_cs_s[0], i_cs_n};
      r_mosi_s  <= {r_mosi_s[0], i_mosi};
      r_sclk_d  <= r_sclk_s[1];
      r_cs_d    <= r_cs_s[1];
      r_rise    <= r_sclk_s[1] & ~r_sclk_d;
      r_fall    <= ~r_sclk_s[1] & r_sclk_d;
      r_cs_fall <= ~r_cs_s[1] & r_cs_d;
      r_cs_rise <= r_cs_s[1] & ~r_cs_d;
      r_mosi    <= r_mosi_s[1];
    end
  end

  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_cs_fall = r_cs_fall;
  assign o_cs_rise = r_cs_rise;
  assign o_mosi    = r_mosi;

endmodule
`default_nettype wire

// File: rtl/spi_psram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_psram_responder: SPI mode-0 READ/WRITE serial-RAM responder     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spi_psram_responder
  import spi_psram_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic sclk_in,
  input  logic cs_n_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic busy_out,
  output logic wr_strobe_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic w_rise, w_fall, w_cs_fall, w_cs_rise, w_mosi;

  spi_input_sync u_sync (
    .clk      (clk_in),
    .rst_n    (reset_n_in),
    .i_sclk   (sclk_in),
    .i_cs_n   (cs_n_in),
    .i_mosi   (mosi_in),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_cs_fall(w_cs_fall),
    .o_cs_rise(w_cs_rise),
    .o_mosi   (w_mosi)
  );

  spi_resp_state_t   r_state;
  logic [2:0]        r_bit_cnt;
  logic [1:0]        r_addr_byte;
  // Only the low ADDR_W address bits matter; older bits fall off the end.
  logic [ADDR_W-2:0] r_addr_sr;
  logic [ADDR_W-1:0] r_addr;
  logic [6:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_is_read;
  logic              r_miso;
  logic              r_wr_strobe;
  logic [7:0]        r_mem [DEPTH];

  logic              w_byte_done;
  logic [7:0]        w_rx_byte;
  logic [ADDR_W-1:0] w_addr_full;

  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx, w_mosi};
  assign w_addr_full = {r_addr_sr, w_mosi};

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_addr_byte <= 2'd0;
      r_addr_sr   <= '0;
      r_addr      <= '0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_is_read   <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_wr_strobe <= 1'b0;
      // CS release outranks any same-cycle bit, so a last-bit race drops the byte.
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_miso    <= 1'b0;
        r_bit_cnt <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state     <= ST_CMD;
              r_bit_cnt   <= 3'd0;
              r_addr_byte <= 2'd0;
            end
          end
          ST_CMD: begin
            if (w_rise) begin
              r_rx      <= w_rx_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_is_read <= (w_rx_byte == SPI_CMD_READ);
                if (w_rx_byte == SPI_CMD_READ || w_rx_byte == SPI_CMD_WRITE)
                  r_state <= ST_ADDR;
                else
                  r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_addr_sr <= w_addr_full[ADDR_W-2:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_addr_byte <= r_addr_byte + 2'd1;
                if (r_addr_byte == 2'd2) begin
                  if (r_is_read) begin
                    r_tx    <= r_mem[w_addr_full];
                    r_addr  <= w_addr_full + 1'b1;
                    r_state <= ST_RD_DATA;
                  end else begin
                    r_addr  <= w_addr_full;
                    r_state <= ST_WR_DATA;
                  end
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (w_fall) begin
              r_miso    <= r_tx[7];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_tx   <= r_mem[r_addr];
                r_addr <= r_addr + 1'b1;
              end else begin
                r_tx <= {r_tx[6:0], 1'b0};
              end
            end
          end
          ST_WR_DATA: begin
            if (w_rise) begin
              r_rx      <= w_rx_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_mem[r_addr] <= w_rx_byte;
                r_addr        <= r_addr + 1'b1;
                r_wr_strobe   <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign miso_out      = r_miso;
  assign busy_out      = (r_state != ST_IDLE);
  assign wr_strobe_out = r_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_spi_psram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_psram_responder: directed SPI master with read scoreboard    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_spi_psram_responder;

  localparam int HALF = 8;

  logic clk_in = 1'b0;
  logic reset_n_in, sclk_in, cs_n_in, mosi_in;
  logic miso_out, busy_out, wr_strobe_out;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  logic ign_window = 1'b0;
  logic ign_miso_hi = 1'b0;

  logic [7:0] model [256];
  logic [7:0] sb_q [$];

  spi_psram_responder #(.ADDR_W(8)) dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .sclk_in      (sclk_in),
    .cs_n_in      (cs_n_in),
    .mosi_in      (mosi_in),
    .miso_out     (miso_out),
    .busy_out     (busy_out),
    .wr_strobe_out(wr_strobe_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (wr_strobe_out) strobe_cnt++;
    if (ign_window && miso_out) ign_miso_hi = 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi_in = b;
    repeat (HALF) @(negedge clk_in);
    r = miso_out;
    sclk_in = 1'b1;
    repeat (HALF) @(negedge clk_in);
    sclk_in = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(t[i], b);
      r[i] = b;
    end
  endtask

  task automatic cs_start();
    cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk_in);
  endtask

  task automatic cs_stop(input string tag);
    int n;
    repeat (HALF) @(negedge clk_in);
    cs_n_in = 1'b1;
    n = 0;
    while (busy_out && n < 12) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, {31'd0, busy_out}, 32'd0);
    repeat (6) @(negedge clk_in);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    spi_byte(cmd, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
  endtask

  task automatic write2(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input string tag);
    logic [7:0] r;
    logic [7:0] a0, a1;
    int s0;
    s0 = strobe_cnt;
    a0 = a[7:0];
    a1 = a0 + 8'd1;
    cs_start();
    send_hdr(8'h02, a);
    spi_byte(d0, r);
    spi_byte(d1, r);
    cs_stop({tag, "_busy"});
    model[a0] = d0;
    model[a1] = d1;
    chk({tag, "_strobes"}, strobe_cnt - s0, 32'd2);
  endtask

  task automatic read2(input logic [23:0] a, input string tag);
    logic [7:0] r, e;
    logic [7:0] a0, a1;
    a0 = a[7:0];
    a1 = a0 + 8'd1;
    sb_q.push_back(model[a0]);
    sb_q.push_back(model[a1]);
    cs_start();
    send_hdr(8'h03, a);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, r);
      e = sb_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, r}, {24'd0, e});
    end
    cs_stop({tag, "_busy"});
  endtask

  initial begin
    logic [7:0] r;
    logic b;
    int s0;

    foreach (model[i]) model[i] = 8'h00;
    reset_n_in = 1'b0;
    sclk_in = 1'b0;
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("rst_miso", {31'd0, miso_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_strobe", {31'd0, wr_strobe_out}, 32'd0);
    reset_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    write2(24'h000010, 8'hA5, 8'h3C, "wr10");
    read2(24'h000010, "rd10");

    write2(24'h0000FF, 8'h11, 8'h22, "wrFF");
    read2(24'h0000FF, "rdFF");
    read2(24'h000000, "rd00");

    // Write cut off after five data bits: nothing must land.
    s0 = strobe_cnt;
    cs_start();
    send_hdr(8'h02, 24'h000020);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    cs_stop("partial_busy");
    chk("partial_strobes", strobe_cnt - s0, 32'd0);
    read2(24'h000020, "rd20");

    // Unknown command followed by 32 clocks.
    s0 = strobe_cnt;
    ign_miso_hi = 1'b0;
    cs_start();
    ign_window = 1'b1;
    spi_byte(8'h9F, r);
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'hFF, r);
      chk($sformatf("ign_rx%0d", k), {24'd0, r}, 32'd0);
    end
    cs_stop("ign_busy");
    ign_window = 1'b0;
    chk("ign_miso_held", {31'd0, ign_miso_hi}, 32'd0);
    chk("ign_strobes", strobe_cnt - s0, 32'd0);
    read2(24'h000010, "rd10_after_ign");

    // Reset during the address phase of a READ.
    cs_start();
    spi_byte(8'h03, r);
    for (int i = 0; i < 12; i++) spi_bit(1'b0, b);
    chk("midrd_busy_before", {31'd0, busy_out}, 32'd1);
    reset_n_in = 1'b0;
    #1;
    chk("midrd_rst_miso", {31'd0, miso_out}, 32'd0);
    chk("midrd_rst_busy", {31'd0, busy_out}, 32'd0);
    chk("midrd_rst_strobe", {31'd0, wr_strobe_out}, 32'd0);
    foreach (model[i]) model[i] = 8'h00;
    cs_n_in = 1'b1;
    sclk_in = 1'b0;
    repeat (4) @(negedge clk_in);
    reset_n_in = 1'b1;
    repeat (6) @(negedge clk_in);
    read2(24'h000010, "rd10_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
